// File: rtl/instr_reg_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_reg_arbiter: round-robin two-requester front end for a ring of     |
// | DEPTH instruction-register slots, with write/read pointers and count.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module instr_reg_arbiter #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [3:0]    req0_opcode,
  input  logic [31:0]   req0_op_a,
  input  logic [31:0]   req0_op_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [3:0]    req1_opcode,
  input  logic [31:0]   req1_op_a,
  input  logic [31:0]   req1_op_b,
  input  logic          pop_req,
  output logic          pop_valid,
  output logic          load_en,
  output logic [3:0]    opcode,
  output logic [31:0]   operand_a,
  output logic [31:0]   operand_b,
  output logic [AW-1:0] write_pointer,
  output logic [AW-1:0] read_pointer,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          init_cnt_q, init_cnt_d;
  logic          prio_q, prio_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic [AW:0]   count_q, count_d;
  logic          load_en_q, load_en_d;
  logic          pop_valid_q, pop_valid_d;
  logic [3:0]    opcode_q, opcode_d;
  logic [31:0]   operand_a_q, operand_a_d;
  logic [31:0]   operand_b_q, operand_b_d;
  logic [AW-1:0] write_pointer_q, write_pointer_d;
  logic [AW-1:0] read_pointer_q, read_pointer_d;

  logic run, winner, wr_fire, rd_fire;

  function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx);
    return (idx == AW'(DEPTH - 1)) ? '0 : idx + AW'(1);
  endfunction

  always_comb begin
    run   = (state_q == RUN);
    full  = (count_q == (AW+1)'(DEPTH));
    empty = (count_q == '0);

    // With no requester valid, the priority holder is shown as the winner.
    if (req0_valid && req1_valid) winner = prio_q;
    else if (req1_valid)          winner = 1'b1;
    else if (req0_valid)          winner = 1'b0;
    else                          winner = prio_q;

    req0_ready = run && !full && !winner;
    req1_ready = run && !full &&  winner;
    wr_fire    = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    rd_fire    = run && pop_req && !empty;
  end

  always_comb begin
    state_d         = state_q;
    init_cnt_d      = init_cnt_q;
    prio_d          = prio_q;
    wr_idx_d        = wr_idx_q;
    rd_idx_d        = rd_idx_q;
    count_d         = count_q;
    load_en_d       = 1'b0;
    pop_valid_d     = 1'b0;
    opcode_d        = opcode_q;
    operand_a_d     = operand_a_q;
    operand_b_d     = operand_b_q;
    write_pointer_d = write_pointer_q;
    read_pointer_d  = read_pointer_q;

    case (state_q)
      INIT: begin
        init_cnt_d = 1'b1;
        if (init_cnt_q) state_d = RUN;
      end
      RUN: begin
        if (wr_fire) begin
          load_en_d       = 1'b1;
          opcode_d        = winner ? req1_opcode : req0_opcode;
          operand_a_d     = winner ? req1_op_a   : req0_op_a;
          operand_b_d     = winner ? req1_op_b   : req0_op_b;
          write_pointer_d = wr_idx_q;
          wr_idx_d        = next_idx(wr_idx_q);
          prio_d          = !winner;
        end
        if (rd_fire) begin
          pop_valid_d    = 1'b1;
          read_pointer_d = rd_idx_q;
          rd_idx_d       = next_idx(rd_idx_q);
        end
        case ({wr_fire, rd_fire})
          2'b10:   count_d = count_q + (AW+1)'(1);
          2'b01:   count_d = count_q - (AW+1)'(1);
          default: count_d = count_q;
        endcase
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= INIT;
      init_cnt_q      <= 1'b0;
      prio_q          <= 1'b0;
      wr_idx_q        <= '0;
      rd_idx_q        <= '0;
      count_q         <= '0;
      load_en_q       <= 1'b0;
      pop_valid_q     <= 1'b0;
      opcode_q        <= '0;
      operand_a_q     <= '0;
      operand_b_q     <= '0;
      write_pointer_q <= '0;
      read_pointer_q  <= AW'(DEPTH - 1);
    end else begin
      state_q         <= state_d;
      init_cnt_q      <= init_cnt_d;
      prio_q          <= prio_d;
      wr_idx_q        <= wr_idx_d;
      rd_idx_q        <= rd_idx_d;
      count_q         <= count_d;
      load_en_q       <= load_en_d;
      pop_valid_q     <= pop_valid_d;
      opcode_q        <= opcode_d;
      operand_a_q     <= operand_a_d;
      operand_b_q     <= operand_b_d;
      write_pointer_q <= write_pointer_d;
      read_pointer_q  <= read_pointer_d;
    end
  end

  assign load_en       = load_en_q;
  assign pop_valid     = pop_valid_q;
  assign opcode        = opcode_q;
  assign operand_a     = operand_a_q;
  assign operand_b     = operand_b_q;
  assign write_pointer = write_pointer_q;
  assign read_pointer  = read_pointer_q;
  assign count         = count_q;

endmodule
`default_nettype wire
